// File: rtl/dmem_axi_pkg.sv
// Shared types and helpers for the MEM-stage data-memory AXI4-Lite controller.
package dmem_axi_pkg;

    // Controller sequencing states: one read (AR/R) or one write (AW/W/B) per instruction.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5
    } dmem_state_e;

    // AXI response codes; anything other than OKAY is a bus error.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One byte lane of the bit mask collapses to one strobe bit: the lane is
    // written when any of its eight mask bits is set.
    function automatic logic mask_to_strb(input logic [7:0] mask_byte);
        return |mask_byte;
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Transaction watchdog: counts enabled cycles, cleared on demand, and pulses
// 'hit' on the cycle whose count reaches LIMIT. LIMIT of 0 disables it.
module dmem_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM_C    = CW'(LIMIT);
    localparam logic [CW-1:0] LIM_M1_C = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          hit_s;

    // Next count and expiry pulse; the counter saturates at LIMIT so expiry fires once.
    always_comb begin
        cnt_nxt_s = cnt_r;
        hit_s     = 1'b0;
        if (clr) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (en && (LIMIT != 0) && (cnt_r != LIM_C)) begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            hit_s     = (cnt_r == LIM_M1_C);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign hit = hit_s;

endmodule

// File: rtl/dmem_axi_ctrl.sv
// MEM-stage data-memory controller: turns EX/MEM load/store requests into a
// single AXI4-Lite read or write, stalls the pipeline until it completes, and
// reports read data and a sticky bus-error flag to MEM/WB.
module dmem_axi_ctrl
    import dmem_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemRead_in,
    input  logic                MemWrite_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [DATA_W-1:0]   wmask_in,
    output logic                CPU_stall,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                done_out,
    output logic                bus_err_out,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam int STRB_W = DATA_W / 8;

    dmem_state_e       state_r, state_nxt_s;
    logic              arvalid_r, arvalid_nxt_s;
    logic              rready_r, rready_nxt_s;
    logic              awvalid_r, awvalid_nxt_s;
    logic              wvalid_r, wvalid_nxt_s;
    logic              bready_r, bready_nxt_s;
    logic              aw_done_r, aw_done_nxt_s;
    logic              w_done_r, w_done_nxt_s;
    logic              done_r, done_nxt_s;
    logic              bus_err_r, bus_err_nxt_s;
    logic [ADDR_W-1:0] araddr_r, araddr_nxt_s;
    logic [ADDR_W-1:0] awaddr_r, awaddr_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
    logic [STRB_W-1:0] wstrb_r, wstrb_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic [STRB_W-1:0] strb_s;
    logic              wd_clr_s, wd_en_s, wd_hit_s;

    // Byte strobes derived lane by lane from the bit-level write mask.
    always_comb begin
        strb_s = {STRB_W{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            strb_s[i] = mask_to_strb(wmask_in[8*i +: 8]);
        end
    end

    // Watchdog runs only while a bus transaction is outstanding.
    always_comb begin
        wd_clr_s = (state_r == IDLE);
        wd_en_s  = (state_r == RD_A) || (state_r == RD_D) ||
                   (state_r == WR_AW) || (state_r == WR_B);
    end

    dmem_watchdog #(
        .LIMIT (TO_CYC)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr_s),
        .en  (wd_en_s),
        .hit (wd_hit_s)
    );

    // Next-state and next-output logic; every register holds unless a transition changes it.
    always_comb begin
        state_nxt_s   = state_r;
        arvalid_nxt_s = arvalid_r;
        rready_nxt_s  = rready_r;
        awvalid_nxt_s = awvalid_r;
        wvalid_nxt_s  = wvalid_r;
        bready_nxt_s  = bready_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        araddr_nxt_s  = araddr_r;
        awaddr_nxt_s  = awaddr_r;
        wdata_nxt_s   = wdata_r;
        wstrb_nxt_s   = wstrb_r;
        rdata_nxt_s   = rdata_r;
        done_nxt_s    = 1'b0;
        bus_err_nxt_s = bus_err_r | wd_hit_s;

        case (state_r)
            IDLE: begin
                // A store takes priority; a simultaneous load request is dropped.
                if (MemWrite_in) begin
                    state_nxt_s   = WR_AW;
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                    awaddr_nxt_s  = addr_in;
                    wdata_nxt_s   = wdata_in;
                    wstrb_nxt_s   = strb_s;
                end else if (MemRead_in) begin
                    state_nxt_s   = RD_A;
                    arvalid_nxt_s = 1'b1;
                    araddr_nxt_s  = addr_in;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end

            RD_A: begin
                if (ARREADY) begin
                    state_nxt_s   = RD_D;
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s   = RD_A;
                end
            end

            RD_D: begin
                if (RVALID) begin
                    state_nxt_s   = DONE;
                    rready_nxt_s  = 1'b0;
                    rdata_nxt_s   = RDATA;
                    done_nxt_s    = 1'b1;
                    bus_err_nxt_s = bus_err_r | wd_hit_s | (RRESP != RESP_OKAY);
                end else begin
                    state_nxt_s   = RD_D;
                end
            end

            WR_AW: begin
                // AW and W complete independently, possibly in the same cycle.
                aw_done_nxt_s = aw_done_r | (awvalid_r & AWREADY);
                w_done_nxt_s  = w_done_r | (wvalid_r & WREADY);
                awvalid_nxt_s = awvalid_r & ~AWREADY;
                wvalid_nxt_s  = wvalid_r & ~WREADY;
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    state_nxt_s   = WR_B;
                    bready_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s   = WR_AW;
                end
            end

            WR_B: begin
                if (BVALID) begin
                    state_nxt_s   = DONE;
                    bready_nxt_s  = 1'b0;
                    done_nxt_s    = 1'b1;
                    bus_err_nxt_s = bus_err_r | wd_hit_s | (BRESP != RESP_OKAY);
                end else begin
                    state_nxt_s   = WR_B;
                end
            end

            DONE: begin
                state_nxt_s = IDLE;
            end

            default: begin
                state_nxt_s   = IDLE;
                arvalid_nxt_s = 1'b0;
                rready_nxt_s  = 1'b0;
                awvalid_nxt_s = 1'b0;
                wvalid_nxt_s  = 1'b0;
                bready_nxt_s  = 1'b0;
                aw_done_nxt_s = 1'b0;
                w_done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every VALID/READY in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            done_r    <= 1'b0;
            bus_err_r <= 1'b0;
            araddr_r  <= {ADDR_W{1'b0}};
            awaddr_r  <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= {STRB_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            arvalid_r <= arvalid_nxt_s;
            rready_r  <= rready_nxt_s;
            awvalid_r <= awvalid_nxt_s;
            wvalid_r  <= wvalid_nxt_s;
            bready_r  <= bready_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            done_r    <= done_nxt_s;
            bus_err_r <= bus_err_nxt_s;
            araddr_r  <= araddr_nxt_s;
            awaddr_r  <= awaddr_nxt_s;
            wdata_r   <= wdata_nxt_s;
            wstrb_r   <= wstrb_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    // Stall asserts as soon as a request is seen in IDLE and releases in DONE,
    // so EX/MEM advances exactly once per access.
    assign CPU_stall = ((state_r == IDLE) && (MemRead_in || MemWrite_in)) ||
                       ((state_r != IDLE) && (state_r != DONE));

    assign rdata_out   = rdata_r;
    assign done_out    = done_r;
    assign bus_err_out = bus_err_r;
    assign AWADDR      = awaddr_r;
    assign AWVALID     = awvalid_r;
    assign WDATA       = wdata_r;
    assign WSTRB       = wstrb_r;
    assign WVALID      = wvalid_r;
    assign BREADY      = bready_r;
    assign ARADDR      = araddr_r;
    assign ARVALID     = arvalid_r;
    assign RREADY      = rready_r;

endmodule
